// File: rtl/eka_mem_arbiter.sv
// Multi-cycle sequencer for the Eka core: one memory port shared between
// instruction fetch and at most one load/store per instruction.
module eka_mem_arbiter #(
    parameter int          ADDR_WIDTH = 32,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [31:0]           core_wr_data,
    input  logic                  core_mem_rd,
    input  logic                  core_mem_wr,
    output logic [31:0]           instruction,
    output logic [31:0]           core_rd_data,
    output logic                  core_step,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  req_wr,
    output logic [31:0]           req_wdata,
    input  logic                  rsp_valid,
    input  logic [31:0]           rsp_data,
    output logic [31:0]           instret,
    output logic                  protocol_err
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_FWAIT  = 3'd1,
        S_DECODE = 3'd2,
        S_DATA   = 3'd3,
        S_DWAIT  = 3'd4,
        S_COMMIT = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_instr;
    logic [31:0] r_rd_data;
    logic [31:0] r_instret;
    logic        r_wr;
    logic        r_err;
    logic        r_drop;
    logic        w_rsp_live;
    logic        w_rsp_wait;
    logic        w_rsp_spurious;
    logic        w_both;

    // Response qualification; r_drop swallows the reply owed to a request aborted by reset
    always_comb begin
        w_rsp_live     = rsp_valid & ~r_drop;
        w_rsp_wait     = (r_state == S_FWAIT) || (r_state == S_DWAIT);
        w_rsp_spurious = w_rsp_live & ~w_rsp_wait;
        w_both         = (r_state == S_DECODE) & core_mem_rd & core_mem_wr;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (req_ready) w_next = S_FWAIT;
                else           w_next = S_FETCH;
            end
            S_FWAIT: begin
                if (w_rsp_live) w_next = S_DECODE;
                else            w_next = S_FWAIT;
            end
            S_DECODE: begin
                if (core_mem_rd || core_mem_wr) w_next = S_DATA;
                else                            w_next = S_COMMIT;
            end
            S_DATA: begin
                if (req_ready) w_next = S_DWAIT;
                else           w_next = S_DATA;
            end
            S_DWAIT: begin
                if (w_rsp_live) w_next = S_COMMIT;
                else            w_next = S_DWAIT;
            end
            S_COMMIT: w_next = S_FETCH;
            default:  w_next = S_FETCH;
        endcase
    end

    // Memory request and commit outputs, decoded from the state register
    always_comb begin
        req_valid = 1'b0;
        req_addr  = inst_addr;
        req_wr    = 1'b0;
        req_wdata = 32'd0;
        case (r_state)
            S_FETCH: begin
                req_valid = ~reset;
            end
            S_DATA: begin
                req_valid = ~reset;
                req_addr  = data_addr;
                req_wr    = r_wr;
                req_wdata = core_wr_data;
            end
            default: begin
                req_valid = 1'b0;
            end
        endcase
        core_step = (r_state == S_COMMIT) & ~reset;
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_instr   <= NOP_INSTR;
            r_rd_data <= 32'd0;
            r_instret <= 32'd0;
            r_wr      <= 1'b0;
            r_err     <= 1'b0;
            r_drop    <= (w_rsp_wait | r_drop) & ~rsp_valid;
        end else begin
            r_state <= w_next;
            if (rsp_valid && r_drop) r_drop <= 1'b0;
            if ((r_state == S_FWAIT) && w_rsp_live) r_instr <= rsp_data;
            // Conflicting decode resolves to a write, latched so the request stays stable
            if (r_state == S_DECODE) r_wr <= core_mem_wr;
            if ((r_state == S_DWAIT) && w_rsp_live && !r_wr) r_rd_data <= rsp_data;
            if (r_state == S_COMMIT) r_instret <= r_instret + 32'd1;
            if (w_rsp_spurious || w_both) r_err <= 1'b1;
        end
    end

    assign instruction  = r_instr;
    assign core_rd_data = r_rd_data;
    assign instret      = r_instret;
    assign protocol_err = r_err;

endmodule

// File: tb/tb_eka_mem_arbiter.sv
// Bench for eka_mem_arbiter: plays core and variable-latency memory, and
// predicts per-instruction cycle counts, fetched words and load data.
module tb_eka_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] inst_addr, data_addr, core_wr_data;
    logic        core_mem_rd, core_mem_wr;
    logic [31:0] instruction, core_rd_data;
    logic        core_step;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic        req_wr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [31:0] instret;
    logic        protocol_err;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] exp_instret, exp_rd, pc;
    logic        exp_err;

    always #5 clk = ~clk;

    eka_mem_arbiter #(.ADDR_WIDTH(32), .NOP_INSTR(32'h0000_0013)) dut (
        .clk(clk), .reset(reset), .inst_addr(inst_addr), .data_addr(data_addr),
        .core_wr_data(core_wr_data), .core_mem_rd(core_mem_rd), .core_mem_wr(core_mem_wr),
        .instruction(instruction), .core_rd_data(core_rd_data), .core_step(core_step),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_wr(req_wr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .instret(instret), .protocol_err(protocol_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Memory side of one request: wait for it, stall, accept, delay, respond
    task automatic serve(input string tag, input int stall, input int lat, input logic [31:0] data,
                         input logic [31:0] exp_addr, input logic exp_wr, input logic [31:0] exp_wdata);
        int n = 0;
        while (req_valid !== 1'b1 && n < 16) begin
            tick();
            n++;
        end
        for (int i = 0; i <= stall; i++) begin
            check({tag, " req_valid"}, 32'(req_valid), 32'd1);
            check({tag, " req_addr"}, req_addr, exp_addr);
            check({tag, " req_wr"}, 32'(req_wr), 32'(exp_wr));
            if (exp_wr) check({tag, " req_wdata"}, req_wdata, exp_wdata);
            req_ready = (i == stall);
            tick();
        end
        req_ready = 1'b0;
        for (int i = 0; i < lat; i++) begin
            check({tag, " no second req"}, 32'(req_valid), 32'd0);
            tick();
        end
        check({tag, " no second req"}, 32'(req_valid), 32'd0);
        rsp_valid = 1'b1;
        rsp_data  = data;
        tick();
        rsp_valid = 1'b0;
        rsp_data  = $urandom;
    endtask

    // One full instruction: kind 0 = ALU, 1 = load, 2 = store
    task automatic do_instr(input int kind, input int fs, input int fl, input int ds, input int dl,
                            input logic [31:0] word, input logic [31:0] daddr,
                            input logic [31:0] wdata, input logic [31:0] rdata, input bit spurious);
        int start, exp_cyc, n;
        inst_addr    = pc << 2;
        data_addr    = daddr;
        core_wr_data = wdata;
        core_mem_rd  = (kind == 1);
        core_mem_wr  = (kind == 2);
        #1;
        start = cyc;
        serve("fetch", fs, fl, word, pc << 2, 1'b0, 32'd0);
        if (spurious) begin
            rsp_valid = 1'b1;
            rsp_data  = ~word;
            tick();
            rsp_valid = 1'b0;
            exp_err   = 1'b1;
        end
        if (kind != 0) serve("data", ds, dl, rdata, daddr, kind == 2, wdata);
        if (kind == 1) exp_rd = rdata;
        n = 0;
        while (core_step !== 1'b1 && n < 16) begin
            tick();
            n++;
        end
        exp_cyc = 4 + fs + fl + ((kind != 0) ? (2 + ds + dl) : 0);
        check("core_step", 32'(core_step), 32'd1);
        check("cycles/instr", 32'(cyc - start + 1), 32'(exp_cyc));
        check("instruction", instruction, word);
        check("core_rd_data", core_rd_data, exp_rd);
        check("instret at commit", instret, exp_instret);
        tick();
        exp_instret = exp_instret + 32'd1;
        pc          = pc + 32'd1;
        check("core_step low", 32'(core_step), 32'd0);
        check("instret", instret, exp_instret);
        check("protocol_err", 32'(protocol_err), 32'(exp_err));
    endtask

    task automatic random_instrs(input int count);
        for (int i = 0; i < count; i++) begin
            do_instr($urandom_range(2, 0), $urandom_range(2, 0), $urandom_range(2, 0),
                     $urandom_range(3, 0), $urandom_range(2, 0),
                     $urandom, $urandom & 32'hFFFF_FFFC, $urandom, $urandom, 1'b0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        inst_addr    = 32'd0;
        data_addr    = 32'd0;
        core_wr_data = 32'd0;
        core_mem_rd  = 1'b0;
        core_mem_wr  = 1'b0;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        rsp_data     = 32'd0;
        exp_instret  = 32'd0;
        exp_rd       = 32'd0;
        exp_err      = 1'b0;
        pc           = 32'd0;
        tick();
        tick();
        check("reset req_valid", 32'(req_valid), 32'd0);
        check("reset core_step", 32'(core_step), 32'd0);
        check("reset instruction", instruction, 32'h0000_0013);
        check("reset core_rd_data", core_rd_data, 32'd0);
        check("reset instret", instret, 32'd0);
        check("reset protocol_err", 32'(protocol_err), 32'd0);

        // ALU instruction at address 0 straight out of reset, zero-wait memory
        reset = 1'b0;
        cyc   = 1;
        #1;
        check("req_valid first cycle", 32'(req_valid), 32'd1);
        check("first req_addr", req_addr, 32'd0);
        check("first req_wr", 32'(req_wr), 32'd0);
        do_instr(0, 0, 0, 0, 0, 32'h0010_0093, 32'd0, 32'd0, 32'd0, 1'b0);
        check("first commit cycle", 32'(cyc - 1), 32'd4);

        // Zero-wait load, store with three refused cycles, spurious response in DECODE
        do_instr(1, 0, 0, 0, 0, 32'h0000_2103, 32'h0000_0040, 32'd0, 32'hDEAD_BEEF, 1'b0);
        do_instr(2, 0, 0, 3, 0, 32'h0020_2023, 32'h0000_0100, 32'h1234_5678, 32'hA5A5_A5A5, 1'b0);
        do_instr(0, 0, 0, 0, 0, 32'h0000_0033, 32'd0, 32'd0, 32'd0, 1'b1);
        check("instruction after spurious", instruction, 32'h0000_0033);

        random_instrs(20);

        // Reset while a fetch is outstanding, then the stale response arrives
        inst_addr   = pc << 2;
        core_mem_rd = 1'b0;
        core_mem_wr = 1'b0;
        #1;
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        reset     = 1'b1;
        tick();
        check("abort core_step in reset", 32'(core_step), 32'd0);
        reset = 1'b0;
        #1;
        check("refetch req_valid", 32'(req_valid), 32'd1);
        check("refetch req_addr", req_addr, inst_addr);
        rsp_valid = 1'b1;
        rsp_data  = 32'hBAD0_BAD0;
        tick();
        rsp_valid   = 1'b0;
        exp_instret = 32'd0;
        exp_rd      = 32'd0;
        exp_err     = 1'b0;
        check("abort instruction", instruction, 32'h0000_0013);
        check("abort protocol_err", 32'(protocol_err), 32'd0);
        check("abort core_step", 32'(core_step), 32'd0);
        do_instr(0, 1, 1, 0, 0, 32'h0050_0293, 32'd0, 32'd0, 32'd0, 1'b0);

        // instret wrap
        force dut.r_instret = 32'hFFFF_FFFF;
        #1;
        release dut.r_instret;
        exp_instret = 32'hFFFF_FFFF;
        do_instr(0, 0, 0, 0, 0, 32'h0000_0013, 32'd0, 32'd0, 32'd0, 1'b0);
        check("instret wrapped", instret, 32'd0);

        random_instrs(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/eka_mem_arbiter.md
# eka_mem_arbiter

Multi-cycle sequencer and single-port memory arbiter for the Eka core. It shares one memory port between instruction fetch and load/store traffic. It fetches each instruction into a holding register and performs at most one data access per instruction. It then pulses `core_step`, which gates the core's PC and register-file write enable. The block sits between the core (fetch address, data address, write data, `mem_rd`/`mem_wr` decode outputs) and a variable-latency memory with valid/ready requests and valid-only responses.

## Interface
- `ADDR_WIDTH`, 32: width of instruction and data addresses.
- `NOP_INSTR`, 32'h0000_0013: instruction register value after reset (`addi x0,x0,0`).

- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `inst_addr` in ADDR_WIDTH: core fetch address (`{PC,2'b0}`).
- `data_addr` in ADDR_WIDTH: core load/store address.
- `core_wr_data` in 32: store data from core.
- `core_mem_rd` in 1: decoded load.
- `core_mem_wr` in 1: decoded store.
- `instruction` out 32: registered instruction fed to the core decoder.
- `core_rd_data` out 32: registered load data fed to the core write-back mux.
- `core_step` out 1: one-cycle commit pulse; the core advances PC and writes its register file only when this is high.
- `req_valid` out 1: memory request valid.
- `req_ready` in 1: memory accepts the request this cycle.
- `req_addr` out ADDR_WIDTH: request address.
- `req_wr` out 1: 1 = write, 0 = read.
- `req_wdata` out 32: write data.
- `rsp_valid` in 1: response/ack valid, one cycle per accepted request.
- `rsp_data` in 32: read data; ignored for writes.
- `instret` out 32: committed-instruction counter, wraps modulo 2^32.
- `protocol_err` out 1: sticky error flag.

## Operation
- States: FETCH, FWAIT, DECODE, DATA, DWAIT, COMMIT.
- **FETCH**: `req_valid`=1, `req_addr`=`inst_addr`, `req_wr`=0. On `req_ready` go to FWAIT.
- **FWAIT**: on `rsp_valid`, `instruction` <= `rsp_data`, then go to DECODE.
- **DECODE**: one settle cycle for the core decoder on the registered instruction. If `core_mem_rd`|`core_mem_wr`, go to DATA, else go to COMMIT.
- **DATA**: `req_valid`=1, `req_addr`=`data_addr`, `req_wr`=`core_mem_wr`, `req_wdata`=`core_wr_data`. On `req_ready` go to DWAIT.
- **DWAIT**: on `rsp_valid`, if the access is a read, `core_rd_data` <= `rsp_data`; go to COMMIT.
- **COMMIT**: `core_step`=1 for exactly one cycle, `instret` += 1, then go to FETCH.
- Request fields (`req_addr`, `req_wr`, `req_wdata`) are held stable while `req_valid`=1 and `req_ready`=0. `req_valid` is never withdrawn before acceptance.
- `req_valid`=0 in FWAIT, DECODE, DWAIT and COMMIT.
- At most one request is outstanding at any time.
- `core_mem_rd` and `core_mem_wr` both high in DECODE: perform a write and set `protocol_err`.
- `rsp_valid` in any state other than FWAIT/DWAIT: ignore the data and set `protocol_err`.
- `instruction` and `core_rd_data` change only in FWAIT/DWAIT on `rsp_valid`, so both are stable during COMMIT.
- A store does not modify `core_rd_data`.

## Timing
- Reset values: state=FETCH, `instruction`=`NOP_INSTR`, `core_rd_data`=0, `core_step`=0, `req_valid`=0 during the reset cycle, `instret`=0, `protocol_err`=0.
- First `req_valid` appears in the first cycle after `reset` deasserts.
- Reset asserted mid-operation aborts any request. The arbiter ignores the pending `rsp_valid`, does not flag it as an error, and never issues `core_step` for the aborted instruction.
- The memory returns `rsp_valid` no earlier than the cycle after acceptance.
- With a zero-wait memory (`req_ready`=1, `rsp_valid` on the next cycle):
  - Non-memory instruction: 4 cycles per instruction (FETCH, FWAIT, DECODE, COMMIT).
  - Load/store: 6 cycles per instruction.
- Each stall cycle on `req_ready`=0 or a late `rsp_valid` adds exactly one cycle.
- `core_step` pulses are separated by at least 3 low cycles.
- `instret` updates in the cycle after COMMIT. It wraps from 32'hFFFF_FFFF to 0 with no flag.

## Test plan
- **Reset then zero-wait memory, non-memory instruction at address 0:**
  - `req_valid` rises 1 cycle after reset deasserts with `req_addr`=0 and `req_wr`=0.
  - `core_step` goes high in cycle 4.
  - `instret`=1.
- **Load: `rsp_data`=32'hDEADBEEF on the data read:**
  - `core_rd_data`=32'hDEADBEEF while `core_step`=1.
  - 6 cycles per instruction.
- **Store with `data_addr`=32'h100, `core_wr_data`=32'h1234_5678, `req_ready` held low 3 cycles:**
  - Request fields stay stable for all 4 cycles.
  - `req_wr`=1 and exactly one handshake occurs.
  - The instruction takes 9 cycles.
- **Spurious `rsp_valid` in DECODE:**
  - `protocol_err`=1 and stays set until reset.
  - `instruction` is unchanged.
- **Reset asserted in FWAIT, then a late `rsp_valid`:**
  - No `core_step`.
  - `instruction`=32'h0000_0013.
  - `protocol_err`=0.
  - A new fetch is issued to `inst_addr`.
- **`instret` preloaded (force) to 32'hFFFF_FFFF, one commit:**
  - `instret`=0.
